// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch bus: request/ready handshake with variable latency.
// The fetch unit is the master; the instruction memory is the slave.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches through the imem handshake and
// produces the IF/ID register inputs (instr, pc4, pc8, load enable, bubble strobe).
// Handles hazard stalls, delay-slot branch redirects and interrupt/eret redirects.
// Optional macro FETCH_ALIGN_CHECK_EN: adds if_adel and turns misaligned fetches
// into locally delivered zero words; without it imem_addr[1:0] is forced to 0.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [31:0]     br_target,
    input  logic            int_req,
    input  logic            eret,
    input  logic [31:0]     epc,
    if_fetch_unit_if.master imem,
    output logic [31:0]     instr,
    output logic [31:0]     pc4,
    output logic [31:0]     pc8,
    output logic            ifid_en,
    output logic            ifid_flush
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic            if_adel
`endif
);

    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic        br_pend;
    logic [31:0] br_tgt;
    logic [31:0] redir_tgt;

    logic        redir;
    logic [31:0] redir_target;
    logic [31:0] deliv_pc;
    logic [31:0] nxt;
    logic        fetch_ok;
    logic [31:0] fetch_data;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        hold_adel;
    logic        misal;

    // A misaligned PC never reaches memory; the slot completes at once with a zero word.
    assign misal          = (pc[1:0] != 2'b00);
    assign fetch_ok       = misal | imem.imem_ready;
    assign fetch_data     = misal ? 32'h0 : imem.imem_rdata;
    assign imem.imem_addr = pc;
`else
    assign fetch_ok       = imem.imem_ready;
    assign fetch_data     = imem.imem_rdata;
    assign imem.imem_addr = {pc[31:2], 2'b00};
`endif

    // In DISCARD the PC has not moved, so pc is still the outstanding request address.
    assign redir        = int_req | eret;
    assign redir_target = int_req ? EXC_ENTRY : epc;
    // Sequential successor is relative to the word being delivered (held word in HOLD).
    assign deliv_pc     = (state == HOLD) ? hold_pc : pc;
    assign nxt          = br_taken ? br_target : (br_pend ? br_tgt : deliv_pc + 32'd4);

    // Combinational IF/ID inputs and memory request, all silenced while in reset.
    always_comb begin
        imem.imem_req = 1'b0;
        instr         = 32'h0;
        pc4           = 32'h0;
        pc8           = 32'h0;
        ifid_en       = 1'b0;
        ifid_flush    = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        if_adel       = 1'b0;
`endif
        if (!rst) begin
            case (state)
                FETCH: begin
`ifdef FETCH_ALIGN_CHECK_EN
                    imem.imem_req = !misal;
`else
                    imem.imem_req = 1'b1;
`endif
                    if (redir) begin
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                    end else if (fetch_ok && !stall) begin
                        instr   = fetch_data;
                        pc4     = pc + 32'd4;
                        pc8     = pc + 32'd8;
                        ifid_en = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
                        if_adel = misal;
`endif
                    end else if (!fetch_ok && !stall) begin
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                    end
                end
                HOLD: begin
                    if (redir) begin
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                    end else begin
                        instr   = hold_instr;
                        pc4     = hold_pc + 32'd4;
                        pc8     = hold_pc + 32'd8;
                        ifid_en = !stall;
`ifdef FETCH_ALIGN_CHECK_EN
                        if_adel = hold_adel & !stall;
`endif
                    end
                end
                DISCARD: begin
                    imem.imem_req = 1'b1;
                    ifid_flush    = 1'b1;
                    ifid_en       = !stall;
                end
                default: ;
            endcase
        end
    end

    // PC, fetch FSM and held/pending state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            state      <= FETCH;
            hold_instr <= 32'h0;
            hold_pc    <= 32'h0;
            br_pend    <= 1'b0;
            br_tgt     <= 32'h0;
            redir_tgt  <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
            hold_adel  <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (redir) begin
                        br_pend <= 1'b0;
                        if (fetch_ok) begin
                            pc <= redir_target;
                        end else begin
                            redir_tgt <= redir_target;
                            state     <= DISCARD;
                        end
                    end else if (fetch_ok) begin
                        if (!stall) begin
                            pc      <= nxt;
                            br_pend <= 1'b0;
                        end else begin
                            hold_instr <= fetch_data;
                            hold_pc    <= pc;
                            pc         <= pc + 32'd4;
                            state      <= HOLD;
`ifdef FETCH_ALIGN_CHECK_EN
                            hold_adel  <= misal;
`endif
                        end
                    end else if (!stall && br_taken) begin
                        // Delay slot not fetched yet: remember the target until it is delivered.
                        br_pend <= 1'b1;
                        br_tgt  <= br_target;
                    end
                end
                HOLD: begin
                    if (redir) begin
                        pc      <= redir_target;
                        br_pend <= 1'b0;
                        state   <= FETCH;
                    end else if (!stall) begin
                        pc      <= nxt;
                        br_pend <= 1'b0;
                        state   <= FETCH;
                    end
                end
                DISCARD: begin
                    // The stale request must complete before the redirect takes effect.
                    if (imem.imem_ready) begin
                        pc    <= redir ? redir_target : redir_tgt;
                        state <= FETCH;
                    end else if (redir) begin
                        redir_tgt <= redir_target;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed walk through the fetch
// scenarios, then randomized traffic checked against a program-order model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        int_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] pc8;
    logic        ifid_en;
    logic        ifid_flush;

    int tests = 0;
    int fails = 0;

    if_fetch_unit_if bus();

    if_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .int_req    (int_req),
        .eret       (eret),
        .epc        (epc),
        .imem       (bus),
        .instr      (instr),
        .pc4        (pc4),
        .pc8        (pc8),
        .ifid_en    (ifid_en),
        .ifid_flush (ifid_flush)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_deliver(input string tag, input logic [31:0] p);
        chk({tag, "_en"}, {31'b0, ifid_en}, 32'd1);
        chk({tag, "_flush"}, {31'b0, ifid_flush}, 32'd0);
        chk({tag, "_instr"}, instr, mem_word(p));
        chk({tag, "_pc4"}, pc4, p + 32'd4);
        chk({tag, "_pc8"}, pc8, p + 32'd8);
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_en"}, {31'b0, ifid_en}, 32'd1);
        chk({tag, "_flush"}, {31'b0, ifid_flush}, 32'd1);
        chk({tag, "_instr"}, instr, 32'd0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_pc;
    logic        armed;
    logic [31:0] arm_tgt;
    logic        redir_out;
    logic        prev_wait;
    logic [31:0] prev_addr;
    int          idle;

    initial begin
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        int_req = 1'b0; eret = 1'b0; epc = 32'h0; bus.imem_ready = 1'b0;

        // Reset: everything quiet.
        @(negedge clk);
        chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_en", {31'b0, ifid_en}, 32'd0);
        chk("rst_flush", {31'b0, ifid_flush}, 32'd0);
        next_cycle();
        rst = 1'b0; bus.imem_ready = 1'b1;

        // Back-to-back deliveries from the reset PC.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("seq_addr", bus.imem_addr, 32'h3000 + 32'(i) * 4);
            chk_deliver("seq", 32'h3000 + 32'(i) * 4);
            next_cycle();
        end

        // Three wait cycles: bubbles with a stable address, then delivery.
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_bubble("wait");
            chk("wait_addr", bus.imem_addr, 32'h300C);
            chk("wait_req", {31'b0, bus.imem_req}, 32'd1);
            next_cycle();
        end
        bus.imem_ready = 1'b1;
        @(negedge clk);
        chk_deliver("wait_done", 32'h300C);
        next_cycle();

        // Branch resolved while its delay slot is delivered.
        br_taken = 1'b1; br_target = 32'h3100;
        @(negedge clk);
        chk_deliver("br_slot", 32'h3010);
        next_cycle();
        br_taken = 1'b0;
        @(negedge clk);
        chk("br_addr", bus.imem_addr, 32'h3100);
        chk_deliver("br_tgt", 32'h3100);
        next_cycle();

        // Branch resolved during a wait: target applied after the delay slot.
        bus.imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h3200;
        @(negedge clk);
        chk_bubble("brw_wait");
        next_cycle();
        bus.imem_ready = 1'b1; br_taken = 1'b0;
        @(negedge clk);
        chk_deliver("brw_slot", 32'h3104);
        next_cycle();
        @(negedge clk);
        chk("brw_addr", bus.imem_addr, 32'h3200);
        chk_deliver("brw_tgt", 32'h3200);
        next_cycle();

        // Stall for two cycles while the fetch completes.
        stall = 1'b1;
        @(negedge clk);
        chk("st1_en", {31'b0, ifid_en}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("st2_en", {31'b0, ifid_en}, 32'd0);
        chk("st2_req", {31'b0, bus.imem_req}, 32'd0);
        next_cycle();
        stall = 1'b0;
        @(negedge clk);
        chk_deliver("st_release", 32'h3204);
        chk("st_release_req", {31'b0, bus.imem_req}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("st_after_addr", bus.imem_addr, 32'h3208);
        chk_deliver("st_after", 32'h3208);
        next_cycle();

        // Interrupt while a fetch is outstanding: stale word dropped.
        bus.imem_ready = 1'b0; int_req = 1'b1;
        @(negedge clk);
        chk_bubble("int_req");
        next_cycle();
        int_req = 1'b0;
        @(negedge clk);
        chk_bubble("disc_wait");
        chk("disc_addr", bus.imem_addr, 32'h320C);
        chk("disc_req", {31'b0, bus.imem_req}, 32'd1);
        next_cycle();
        bus.imem_ready = 1'b1;
        @(negedge clk);
        chk_bubble("disc_drop");
        next_cycle();
        @(negedge clk);
        chk("exc_addr", bus.imem_addr, 32'h4180);
        chk_deliver("exc", 32'h4180);
        next_cycle();

        // Return from handler.
        eret = 1'b1; epc = 32'h3020;
        @(negedge clk);
        chk_bubble("eret");
        next_cycle();
        eret = 1'b0;
        @(negedge clk);
        chk("eret_addr", bus.imem_addr, 32'h3020);
        chk_deliver("eret_tgt", 32'h3020);
        next_cycle();

        // Asynchronous reset in the middle of a discard.
        bus.imem_ready = 1'b0; int_req = 1'b1;
        @(negedge clk);
        next_cycle();
        int_req = 1'b0;
        @(negedge clk);
        chk("rdisc_flush", {31'b0, ifid_flush}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", {31'b0, bus.imem_req}, 32'd0);
        chk("arst_en", {31'b0, ifid_en}, 32'd0);
        chk("arst_flush", {31'b0, ifid_flush}, 32'd0);
        next_cycle();
        rst = 1'b0; bus.imem_ready = 1'b1;
        @(negedge clk);
        chk("arst_addr", bus.imem_addr, 32'h3000);
        chk_deliver("arst_first", 32'h3000);
        next_cycle();

        // Reset drops a pending branch.
        bus.imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h3300;
        @(negedge clk);
        next_cycle();
        br_taken = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        next_cycle();
        rst = 1'b0; bus.imem_ready = 1'b1;
        @(negedge clk);
        chk_deliver("bpr_first", 32'h3000);
        next_cycle();
        @(negedge clk);
        chk("bpr_addr", bus.imem_addr, 32'h3004);
        next_cycle();

        // Randomized traffic against a program-order model.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        exp_pc = 32'h3000; armed = 1'b0; arm_tgt = 32'h0; redir_out = 1'b0;
        prev_wait = 1'b0; prev_addr = 32'h0; idle = 0;
        for (int c = 0; c < 1500; c++) begin
            stall = ($urandom % 4) == 0;
            bus.imem_ready = ($urandom % 3) != 0;
            int_req = 1'b0; eret = 1'b0; br_taken = 1'b0;
            if (!stall && !redir_out && ($urandom % 30) == 0) begin
                if (($urandom % 2) == 0) begin
                    int_req = 1'b1;
                end else begin
                    eret = 1'b1;
                    epc  = 32'h6000 + 32'($urandom % 256) * 4;
                end
            end else if (!stall && !redir_out && !armed && ($urandom % 5) == 0) begin
                br_taken  = 1'b1;
                br_target = 32'h7000 + 32'($urandom % 1024) * 4;
            end
            @(negedge clk);
            chk("r_en", {31'b0, ifid_en}, {31'b0, !stall});
            if (int_req || eret)
                chk("r_redir_flush", {31'b0, ifid_flush}, 32'd1);
            if (prev_wait) begin
                chk("r_addr_hold", bus.imem_addr, prev_addr);
                chk("r_req_hold", {31'b0, bus.imem_req}, 32'd1);
            end
            if (ifid_flush)
                chk("r_bubble_instr", instr, 32'd0);
            if (ifid_en && !ifid_flush) begin
                chk("r_instr", instr, mem_word(exp_pc));
                chk("r_pc4", pc4, exp_pc + 32'd4);
                chk("r_pc8", pc8, exp_pc + 32'd8);
                idle = 0;
            end else begin
                idle++;
            end
            chk("r_progress", {31'b0, idle > 60}, 32'd0);
            // Model: a redirect restarts the stream; a branch target follows the
            // first instruction delivered at or after the branch resolves.
            if (int_req || eret) begin
                exp_pc    = int_req ? 32'h4180 : epc;
                armed     = 1'b0;
                redir_out = 1'b1;
            end else begin
                if (br_taken) begin
                    armed   = 1'b1;
                    arm_tgt = br_target;
                end
                if (ifid_en && !ifid_flush) begin
                    exp_pc    = armed ? arm_tgt : exp_pc + 32'd4;
                    armed     = 1'b0;
                    redir_out = 1'b0;
                end
            end
            prev_wait = bus.imem_req && !bus.imem_ready;
            prev_addr = bus.imem_addr;
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
